// File: rtl/pipe_ctrl_unit_if.sv
// Decode-stage bus: IF/ID instruction in, ID/EX control bundle and HI/LO status out.
interface pipe_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [31:0]       instr_id;
  logic              flush;
  logic              ex_regdst;
  logic              ex_alusrc;
  logic              ex_memtoreg;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_jal;
  logic [1:0]        ex_aluop;
  logic [1:0]        ex_resmux;
  logic [REG_AW-1:0] ex_rt;
  logic              stall;
  logic              mul_start;
  logic              hilo_busy;
  logic              illegal;

  modport master (
    output id_valid, instr_id, flush,
    input  ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
           ex_branch, ex_jump, ex_jal, ex_aluop, ex_resmux, ex_rt,
           stall, mul_start, hilo_busy, illegal
  );

  modport slave (
    input  id_valid, instr_id, flush,
    output ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
           ex_branch, ex_jump, ex_jal, ex_aluop, ex_resmux, ex_rt,
           stall, mul_start, hilo_busy, illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// MIPS decode-stage control: decode into ID/EX, load-use and HI/LO hazard stalls,
// and the multu/divu busy sequencer.
module pipe_ctrl_unit #(
  parameter int unsigned MUL_LAT = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_unit_if.slave   bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_ADDIU = 6'h09, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SRL  = 6'h02, FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_MULTU = 6'h19, FN_DIVU = 6'h1B;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       jal;
    logic [1:0] aluop;
    logic [1:0] resmux;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [31:0]       instr;
  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt;
  logic              unused_bits;

  ctrl_t             dec, ex_q;
  logic              known, is_muldiv, is_hilo, uses_rt;
  logic              load_use, hilo_stall, stall, illegal_d, bubble, md_issue;
  logic [REG_AW-1:0] ex_rt_q;
  logic              illegal_q, start_q, start_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign instr       = bus.instr_id;
  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign rs          = REG_AW'(instr[25:21]);
  assign rt          = REG_AW'(instr[20:16]);
  assign unused_bits = ^instr[15:6];

  always_comb begin
    dec       = '0;
    known     = 1'b1;
    is_muldiv = 1'b0;
    is_hilo   = 1'b0;
    uses_rt   = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        if (instr != '0) begin
          case (funct)
            FN_MFHI, FN_MFLO: begin
              dec.regdst = 1'b1; dec.regwrite = 1'b1; dec.resmux = 2'b01;
              is_hilo = 1'b1;
            end
            FN_SRL: begin
              dec.regdst = 1'b1; dec.regwrite = 1'b1; dec.resmux = 2'b11;
            end
            FN_MULTU, FN_DIVU: is_muldiv = 1'b1;
            default: begin
              dec.regdst = 1'b1; dec.regwrite = 1'b1;
              dec.aluop  = 2'b10; dec.resmux = 2'b10;
            end
          endcase
        end
      end
      OP_LW: begin
        dec.alusrc = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1;
        dec.memread = 1'b1; dec.resmux = 2'b10;
      end
      OP_SW: begin
        dec.alusrc = 1'b1; dec.memwrite = 1'b1; dec.resmux = 2'b10;
        uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1; dec.aluop = 2'b01;
        uses_rt = 1'b1;
      end
      OP_J:     dec.jump = 1'b1;
      OP_JAL:   begin dec.jump = 1'b1; dec.jal = 1'b1; dec.regwrite = 1'b1; end
      OP_ADDIU: begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.resmux = 2'b10; end
      default:  known = 1'b0;
    endcase
  end

  // Unknown opcodes read no registers, so they never raise a load-use stall.
  assign load_use   = known & ex_q.memread & (ex_rt_q != '0) &
                      ((ex_rt_q == rs) | (uses_rt & (ex_rt_q == rt)));
  assign hilo_stall = (state_q == S_BUSY) & (is_hilo | is_muldiv);
  assign stall      = bus.id_valid & ~bus.flush & (load_use | hilo_stall);
  assign illegal_d  = bus.id_valid & ~bus.flush & ~known;
  assign bubble     = ~bus.id_valid | bus.flush | stall | ~known;
  assign md_issue   = ~bubble & is_muldiv;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: if (md_issue) begin
        state_d = S_BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 1);
        start_d = 1'b1;
      end
      S_BUSY: if (cnt_q == '0) state_d = S_IDLE;
              else             cnt_d   = cnt_q - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      ex_q      <= '0;
      ex_rt_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      illegal_q <= illegal_d;
      ex_q      <= bubble ? '0 : dec;
      ex_rt_q   <= bubble ? '0 : rt;
    end
  end

  assign bus.ex_regdst   = ex_q.regdst;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_jump     = ex_q.jump;
  assign bus.ex_jal      = ex_q.jal;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_resmux   = ex_q.resmux;
  assign bus.ex_rt       = ex_rt_q;
  assign bus.stall       = stall;
  assign bus.mul_start   = start_q;
  assign bus.hilo_busy   = (state_q == S_BUSY);
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, hazards, HI/LO sequencing, illegal, async reset.
module tb_pipe_ctrl_unit;
  localparam int unsigned MUL_LAT = 32;

  // Expected ID/EX bundles: {regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,jal,aluop,resmux}
  localparam logic [12:0] C_LW    = 13'b0_1_1_1_1_0_0_0_0_00_10;
  localparam logic [12:0] C_ADD   = 13'b1_0_0_1_0_0_0_0_0_10_10;
  localparam logic [12:0] C_MFHI  = 13'b1_0_0_1_0_0_0_0_0_00_01;
  localparam logic [12:0] C_SRL   = 13'b1_0_0_1_0_0_0_0_0_00_11;
  localparam logic [12:0] C_ADDIU = 13'b0_1_0_1_0_0_0_0_0_00_10;
  localparam logic [12:0] C_SW    = 13'b0_1_0_0_0_1_0_0_0_00_10;
  localparam logic [12:0] C_BEQ   = 13'b0_0_0_0_0_0_1_0_0_01_00;
  localparam logic [12:0] C_J     = 13'b0_0_0_0_0_0_0_1_0_00_00;
  localparam logic [12:0] C_JAL   = 13'b0_0_0_1_0_0_0_1_1_00_00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipe_ctrl_unit_if #(.REG_AW(5)) bus ();

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .REG_AW(5), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ex_vec();
    return {bus.ex_regdst, bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite, bus.ex_memread,
            bus.ex_memwrite, bus.ex_branch, bus.ex_jump, bus.ex_jal, bus.ex_aluop, bus.ex_resmux};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic f);
    bus.id_valid = v;
    bus.instr_id = ins;
    bus.flush    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.id_valid = 1'b0;
    bus.instr_id = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex",      32'(ex_vec()), 0);
    check("rst_rt",      32'(bus.ex_rt), 0);
    check("rst_stall",   32'(bus.stall), 0);
    check("rst_busy",    32'(bus.hilo_busy), 0);
    check("rst_start",   32'(bus.mul_start), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    rst = 1'b1;

    // lw $t0 then dependent add: one stall, one bubble, then add
    drive(1, itype(6'h23, 16, 8), 0);
    check("lw_nostall", 32'(bus.stall), 0);
    tick();
    check("lw_ex", 32'(ex_vec()), 32'(C_LW));
    check("lw_rt", 32'(bus.ex_rt), 8);
    drive(1, rtype(8, 10, 9, 6'h20), 0);
    check("lu_stall", 32'(bus.stall), 1);
    tick();
    check("lu_bubble", 32'(ex_vec()), 0);
    check("lu_bubble_rt", 32'(bus.ex_rt), 0);
    check("lu_release", 32'(bus.stall), 0);
    tick();
    check("add_ex", 32'(ex_vec()), 32'(C_ADD));
    check("add_rt", 32'(bus.ex_rt), 10);

    // lw to $0 never creates a hazard
    drive(1, itype(6'h23, 16, 0), 0);
    tick();
    drive(1, rtype(0, 0, 9, 6'h20), 0);
    check("lw0_nostall", 32'(bus.stall), 0);
    tick();
    check("lw0_add_ex", 32'(ex_vec()), 32'(C_ADD));

    // rt compare applies to sw but not to addiu (rt is its destination)
    drive(1, itype(6'h23, 16, 8), 0);
    tick();
    drive(1, itype(6'h2B, 17, 8), 0);
    check("sw_rt_stall", 32'(bus.stall), 1);
    drive(1, itype(6'h09, 17, 8), 0);
    check("addiu_rt_nostall", 32'(bus.stall), 0);
    // flush beats stall for a hazarding beq
    drive(1, itype(6'h04, 8, 9), 0);
    check("beq_stall", 32'(bus.stall), 1);
    drive(1, itype(6'h04, 8, 9), 1);
    check("flush_nostall", 32'(bus.stall), 0);
    tick();
    check("flush_bubble", 32'(ex_vec()), 0);
    check("flush_nostart", 32'(bus.mul_start), 0);
    drive(1, rtype(8, 9, 10, 6'h02), 0);
    tick();
    check("srl_ex", 32'(ex_vec()), 32'(C_SRL));
    drive(1, itype(6'h2B, 8, 9), 0);
    tick();
    check("sw_ex", 32'(ex_vec()), 32'(C_SW));

    // illegal opcode 0x3F
    drive(1, 32'hFC00_0000, 0);
    check("ill_nostall", 32'(bus.stall), 0);
    tick();
    check("ill_pulse", 32'(bus.illegal), 1);
    check("ill_ex", 32'(ex_vec()), 0);
    check("ill_rt", 32'(bus.ex_rt), 0);
    drive(0, 32'h0, 0);
    tick();
    check("ill_end", 32'(bus.illegal), 0);

    // multu then mfhi: MUL_LAT cycles of stall
    drive(1, rtype(8, 9, 0, 6'h19), 0);
    check("multu_nostall", 32'(bus.stall), 0);
    tick();
    check("multu_start", 32'(bus.mul_start), 1);
    check("multu_busy", 32'(bus.hilo_busy), 1);
    check("multu_ex", 32'(ex_vec()), 0);
    drive(1, rtype(0, 0, 10, 6'h10), 0);
    check("mfhi_stall", 32'(bus.stall), 1);
    tick();
    check("start_pulse_end", 32'(bus.mul_start), 0);
    check("mfhi_stall_bubble", 32'(ex_vec()), 0);
    n = 1;
    while (bus.stall === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("hilo_stall_len", 32'(n), MUL_LAT);
    check("busy_cleared", 32'(bus.hilo_busy), 0);
    tick();
    check("mfhi_ex", 32'(ex_vec()), 32'(C_MFHI));

    // divu, then reset 10 cycles into BUSY
    drive(1, rtype(8, 9, 0, 6'h1B), 0);
    tick();
    check("divu_busy", 32'(bus.hilo_busy), 1);
    drive(0, 32'h0, 0);
    repeat (8) tick();
    drive(1, itype(6'h09, 3, 4), 0);
    tick();
    check("addiu_ex_busy", 32'(ex_vec()), 32'(C_ADDIU));
    check("busy_10", 32'(bus.hilo_busy), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.hilo_busy), 0);
    check("rst_mid_ex", 32'(ex_vec()), 0);
    #2;
    rst = 1'b1;
    drive(1, itype(6'h03, 0, 0), 0);
    tick();
    check("jal_ex", 32'(ex_vec()), 32'(C_JAL));
    check("jal_nobusy", 32'(bus.hilo_busy), 0);
    drive(1, itype(6'h02, 0, 0), 0);
    tick();
    check("j_ex", 32'(ex_vec()), 32'(C_J));
    drive(1, itype(6'h04, 1, 2), 0);
    tick();
    check("beq_ex", 32'(ex_vec()), 32'(C_BEQ));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
